// File: rtl/truth_table_sweeper.sv
// Sweeps all input vectors of an N_IN-input function, captures its truth table
// and checks it against a mask. Define TT_STOP_ON_ERR_EN to end on first error.
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      dut_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 mismatch,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      first_err_idx
);

  localparam int W  = 2**N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN:0] LAST = (N_IN+1)'(W-1);
  localparam logic [CW-1:0] CMAX = CW'(SETTLE-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [N_IN:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    exp_q, exp_d;
  logic [W-1:0]    tbl_q, tbl_d;
  logic            mism_q, mism_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ferr_q, ferr_d;
  logic            hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      tbl_q   <= '0;
      mism_q  <= 1'b0;
      err_q   <= '0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      tbl_q   <= tbl_d;
      mism_q  <= mism_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end

  assign hit = dut_out ^ exp_q[idx_q[N_IN-1:0]];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    tbl_d   = tbl_q;
    mism_d  = mism_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d   = expected;
          tbl_d   = '0;
          mism_d  = 1'b0;
          err_d   = '0;
          ferr_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q == CMAX) state_d = S_SAMPLE;
        else cnt_d = cnt_q + CW'(1);
      end
      S_SAMPLE: begin
        tbl_d[idx_q[N_IN-1:0]] = dut_out;
        if (hit) begin
          err_d  = err_q + (N_IN+1)'(1);
          mism_d = 1'b1;
          if (!mism_q) ferr_d = idx_q[N_IN-1:0];
        end
        if (idx_q == LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + (N_IN+1)'(1);
          cnt_d   = '0;
          state_d = S_DRIVE;
        end
`ifdef TT_STOP_ON_ERR_EN
        if (hit) begin
          idx_d   = idx_q;
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  assign dut_in        = idx_q[N_IN-1:0];
  assign busy          = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
  assign done          = (state_q == S_DONE);
  assign table_out     = tbl_q;
  assign mismatch      = mism_q;
  assign err_count     = err_q;
  assign first_err_idx = ferr_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: default instance plus an
// N_IN=2/SETTLE=3 instance; results are queued at start and popped on done.
module tb_truth_table_sweeper;

  typedef struct {
    logic [15:0] tbl;
    logic        mm;
    logic [4:0]  ec;
    logic [3:0]  fe;
    int          lat;
    int          sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int dones_a = 0;
  int dones_b = 0;
  exp_t qa[$];
  exp_t qb[$];

  // instance A: defaults
  logic        start_a = 1'b0;
  logic [15:0] exp_a = '0;
  logic [15:0] model_a = 16'h8C6B;
  logic        dout_a;
  logic [3:0]  din_a;
  logic        busy_a, done_a, mm_a;
  logic [15:0] tbl_a;
  logic [4:0]  ec_a;
  logic [3:0]  fe_a;

  assign dout_a = model_a[din_a];

  truth_table_sweeper u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .expected(exp_a),
    .dut_out(dout_a), .dut_in(din_a), .busy(busy_a), .done(done_a),
    .table_out(tbl_a), .mismatch(mm_a), .err_count(ec_a),
    .first_err_idx(fe_a)
  );

  // instance B: 2-input AND, SETTLE=3
  logic        start_b = 1'b0;
  logic [3:0]  exp_b = '0;
  logic        dout_b;
  logic [1:0]  din_b;
  logic        busy_b, done_b, mm_b;
  logic [3:0]  tbl_b;
  logic [2:0]  ec_b;
  logic [1:0]  fe_b;

  assign dout_b = &din_b;

  truth_table_sweeper #(.N_IN(2), .SETTLE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .expected(exp_b),
    .dut_out(dout_b), .dut_in(din_b), .busy(busy_b), .done(done_b),
    .table_out(tbl_b), .mismatch(mm_b), .err_count(ec_b),
    .first_err_idx(fe_b)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done_a) begin
      exp_t e;
      dones_a++;
      if (qa.size() == 0) begin
        chk("a_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = qa.pop_front();
        chk("a_table", 32'(tbl_a), 32'(e.tbl));
        chk("a_mismatch", 32'(mm_a), 32'(e.mm));
        chk("a_err_count", 32'(ec_a), 32'(e.ec));
        chk("a_first_err", 32'(fe_a), 32'(e.fe));
        chk("a_busy_at_done", 32'(busy_a), 32'd0);
        chk("a_latency", 32'(cyc - e.sc + 1), 32'(e.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done_b) begin
      exp_t e;
      dones_b++;
      if (qb.size() == 0) begin
        chk("b_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = qb.pop_front();
        chk("b_table", 32'(tbl_b), 32'(e.tbl[3:0]));
        chk("b_mismatch", 32'(mm_b), 32'(e.mm));
        chk("b_err_count", 32'(ec_b), 32'(e.ec));
        chk("b_first_err", 32'(fe_b), 32'(e.fe));
        chk("b_latency", 32'(cyc - e.sc + 1), 32'(e.lat));
      end
    end
  end

  task automatic go_a(input logic [15:0] ex, input exp_t e);
    @(negedge clk);
    exp_a = ex;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    e.sc = cyc;
    qa.push_back(e);
  endtask

  task automatic go_b(input logic [3:0] ex, input exp_t e);
    @(negedge clk);
    exp_b = ex;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    e.sc = cyc;
    qb.push_back(e);
  endtask

  task automatic wait_done(input bit b, input int budget);
    int n0;
    bit seen;
    n0 = b ? dones_b : dones_a;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if ((b ? dones_b : dones_a) != n0) seen = 1'b1;
    end
    if (!seen) chk(b ? "b_done_timeout" : "a_done_timeout", 32'd0, 32'd1);
  endtask

  exp_t e_pass, e_fail, e_b;

  initial begin
    e_pass = '{tbl: 16'h8C6B, mm: 1'b0, ec: 5'd0, fe: 4'd0, lat: 33, sc: 0};
`ifdef TT_STOP_ON_ERR_EN
    e_fail = '{tbl: 16'h0001, mm: 1'b1, ec: 5'd1, fe: 4'd0, lat: 3, sc: 0};
`else
    e_fail = '{tbl: 16'h8C6B, mm: 1'b1, ec: 5'd2, fe: 4'd0, lat: 33, sc: 0};
`endif
    e_b = '{tbl: 16'h0008, mm: 1'b0, ec: 5'd0, fe: 4'd0, lat: 17, sc: 0};

    // reset state
    #12;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_table", 32'(tbl_a), 32'd0);
    chk("rst_dut_in", 32'(din_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset mid-sweep at idx 7: no queue entry, so any done is flagged
    @(negedge clk);
    exp_a = 16'h8C6B;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    for (int i = 0; i < 100 && din_a != 4'd7; i++) @(negedge clk);
    chk("reached_idx7", 32'(din_a), 32'd7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_done", 32'(done_a), 32'd0);
    chk("midrst_table", 32'(tbl_a), 32'd0);
    chk("midrst_mismatch", 32'(mm_a), 32'd0);
    chk("midrst_err", 32'(ec_a), 32'd0);
    chk("midrst_first", 32'(fe_a), 32'd0);
    chk("midrst_dut_in", 32'(din_a), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", 32'(dones_a), 32'd0);

    // pass sweep with dut_in sequencing
    go_a(16'h8C6B, e_pass);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk($sformatf("dut_in_%0d", k), 32'(din_a), 32'(k / 2));
      if (k == 0) chk("busy_after_start", 32'(busy_a), 32'd1);
    end
    wait_done(1'b0, 20);
    chk("done_count_1", 32'(dones_a), 32'd1);

    // failing sweep: expected bits 0 and 15 wrong
    go_a(16'h0C6A, e_fail);
    wait_done(1'b0, 60);

    // start pulses and expected changes while busy are ignored
    go_a(16'h8C6B, e_pass);
    chk("clear_mismatch", 32'(mm_a), 32'd0);
    chk("clear_err", 32'(ec_a), 32'd0);
    chk("clear_table", 32'(tbl_a), 32'd0);
    repeat (5) @(negedge clk);
    exp_a = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    wait_done(1'b0, 60);
    chk("done_count_3", 32'(dones_a), 32'd3);

    // start in DONE cycle ignored, next cycle accepted
    exp_a = 16'h0C6A;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    @(negedge clk);
    chk("done_cycle_start_ignored", 32'(busy_a), 32'd0);
    go_a(16'h0C6A, e_fail);
    chk("b2b_busy", 32'(busy_a), 32'd1);
    chk("b2b_clear_table", 32'(tbl_a), 32'd0);
    wait_done(1'b0, 60);

    // small instance
    go_b(4'b1000, e_b);
    wait_done(1'b1, 40);

    repeat (5) @(negedge clk);
    chk("done_count_a", 32'(dones_a), 32'd4);
    chk("done_count_b", 32'(dones_b), 32'd1);
    chk("queue_a_empty", 32'(qa.size()), 32'd0);
    chk("queue_b_empty", 32'(qb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
